// File: rtl/button_debouncer.sv
// Purpose : two-flop synchroniser plus stability qualifier for a bouncy push-button pin.
// Latency : a new level captured by the first sync flop at edge E shows on button_clean at E+1+STABLE_CYCLES.
// Backpres: none; free-running, one raw sample per clock, outputs are always valid.
//
// Ports:
//   CLK          system clock, everything on posedge
//   RST          synchronous active-high reset, overrides all other activity
//   button_raw   asynchronous bouncy button pin
//   button_clean debounced level (registered)
//   rise / fall  one-cycle strobes on the edge button_clean goes 0->1 / 1->0
//   busy         high while a candidate level change is being qualified
module button_debouncer #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic button_raw,
  output logic button_clean,
  output logic rise,
  output logic fall,
  output logic busy
);

  typedef enum logic {
    IDLE = 1'b0,
    QUAL = 1'b1
  } state_t;

  // Count value at which the next differing sample completes qualification.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // With a single-sample requirement the first differing sample is accepted
  // directly from IDLE and QUAL is never entered.
  localparam bit SINGLE = (STABLE_CYCLES == 1);

  state_t           state_q;
  logic             sync0_q;
  logic             sync1_q;
  logic             clean_q;
  logic             rise_q;
  logic             fall_q;
  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync0_q <= button_raw;
      sync1_q <= sync0_q;
      // Strobes are single-cycle: cleared unless an acceptance sets them below.
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;

      case (state_q)
        IDLE: begin
          if (sync1_q != clean_q) begin
            if (SINGLE) begin
              clean_q <= sync1_q;
              rise_q  <= sync1_q;
              fall_q  <= ~sync1_q;
              cnt_q   <= '0;
            end else begin
              state_q <= QUAL;
              busy_q  <= 1'b1;
              cnt_q   <= CNT_ONE;
            end
          end else begin
            cnt_q <= '0;
          end
        end

        QUAL: begin
          if (sync1_q == clean_q) begin
            // Bounced back to the current level: abandon the candidate.
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            clean_q <= sync1_q;
            rise_q  <= sync1_q;
            fall_q  <= ~sync1_q;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign button_clean = clean_q;
  assign rise         = rise_q;
  assign fall         = fall_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_button_debouncer.sv
module tb_button_debouncer;

  localparam int SC = 4;

  logic CLK        = 1'b0;
  logic RST        = 1'b1;
  logic button_raw = 1'b0;
  logic button_clean;
  logic rise;
  logic fall;
  logic busy;

  int n_vec  = 0;
  int n_bad  = 0;
  int n_rise = 0;
  int n_fall = 0;

  button_debouncer #(
    .STABLE_CYCLES(SC),
    .CNT_W        (8)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .button_raw  (button_raw),
    .button_clean(button_clean),
    .rise        (rise),
    .fall        (fall),
    .busy        (busy)
  );

  always #10 CLK = ~CLK;

  // Reference model: the level the debouncer logic sees is the pin value from two
  // edges earlier; the output takes a new value once the last SC observed samples
  // all differ from the current output.
  bit m_pipe[2];
  bit m_hist[SC];
  bit m_clean = 1'b0;
  bit m_rise  = 1'b0;
  bit m_fall  = 1'b0;
  bit m_busy  = 1'b0;

  task automatic model_step(input bit rst, input bit raw);
    bit s;
    bit prev;
    bit all_diff;
    if (rst) begin
      m_pipe[0] = 1'b0;
      m_pipe[1] = 1'b0;
      for (int i = 0; i < SC; i++) m_hist[i] = 1'b0;
      m_clean = 1'b0;
      m_rise  = 1'b0;
      m_fall  = 1'b0;
      m_busy  = 1'b0;
    end else begin
      s         = m_pipe[0];
      m_pipe[0] = m_pipe[1];
      m_pipe[1] = raw;
      for (int i = 0; i < SC - 1; i++) m_hist[i] = m_hist[i+1];
      m_hist[SC-1] = s;
      prev     = m_clean;
      all_diff = 1'b1;
      for (int i = 0; i < SC; i++) if (m_hist[i] == m_clean) all_diff = 1'b0;
      if (all_diff) m_clean = s;
      m_rise = m_clean && !prev;
      m_fall = !m_clean && prev;
      m_busy = (s != m_clean);
    end
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input bit rst, input bit raw);
    RST        = rst;
    button_raw = raw;
    @(posedge CLK);
    model_step(rst, raw);
    #1;
    if (rise === 1'b1) n_rise++;
    if (fall === 1'b1) n_fall++;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".clean"}, button_clean, m_clean);
    check({tag, ".rise"},  rise,         m_rise);
    check({tag, ".fall"},  fall,         m_fall);
    check({tag, ".busy"},  busy,         m_busy);
    check({tag, ".excl"},  rise & fall,  1'b0);
  endtask

  task automatic apply_chk(input bit rst, input bit raw, input string tag);
    apply(rst, raw);
    check_model(tag);
  endtask

  // Holds raw steady and returns how many edges after the capture edge the
  // requested strobe appears (-1 if it never does within the budget).
  task automatic edges_until(input bit want_rise, input bit raw, input string tag, output int n);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      apply_chk(1'b0, raw, tag);
      if ((want_rise ? rise : fall) === 1'b1) begin
        n = i - 1;
        break;
      end
    end
  endtask

  typedef struct {
    bit rst;
    bit raw;
    bit clean;
    bit rs;
    bit fl;
    bit bsy;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int n;
    int base;

    // reset, clean press, short low glitch while high
    tbl[0]  = '{1, 1, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 0, 0, 0, 0};
    tbl[3]  = '{0, 1, 0, 0, 0, 0};
    tbl[4]  = '{0, 1, 0, 0, 0, 1};
    tbl[5]  = '{0, 1, 0, 0, 0, 1};
    tbl[6]  = '{0, 1, 0, 0, 0, 1};
    tbl[7]  = '{0, 1, 1, 1, 0, 0};
    tbl[8]  = '{0, 1, 1, 0, 0, 0};
    tbl[9]  = '{0, 1, 1, 0, 0, 0};
    tbl[10] = '{0, 0, 1, 0, 0, 0};
    tbl[11] = '{0, 0, 1, 0, 0, 0};
    tbl[12] = '{0, 1, 1, 0, 0, 1};
    tbl[13] = '{0, 1, 1, 0, 0, 1};
    tbl[14] = '{0, 1, 1, 0, 0, 0};
    tbl[15] = '{0, 1, 1, 0, 0, 0};

    for (int i = 0; i < 16; i++) begin
      apply(tbl[i].rst, tbl[i].raw);
      check($sformatf("tbl[%0d].clean", i), button_clean, tbl[i].clean);
      check($sformatf("tbl[%0d].rise", i),  rise,         tbl[i].rs);
      check($sformatf("tbl[%0d].fall", i),  fall,         tbl[i].fl);
      check($sformatf("tbl[%0d].busy", i),  busy,         tbl[i].bsy);
    end

    // release with three one-cycle bounces, then stable low
    base = n_fall;
    apply_chk(1'b0, 1'b0, "bnc");
    apply_chk(1'b0, 1'b1, "bnc");
    apply_chk(1'b0, 1'b0, "bnc");
    apply_chk(1'b0, 1'b1, "bnc");
    apply_chk(1'b0, 1'b0, "bnc");
    apply_chk(1'b0, 1'b1, "bnc");
    edges_until(1'b0, 1'b0, "bnc_settle", n);
    check("bnc_fall_latency5", (n == 5), 1'b1);
    for (int i = 0; i < 10; i++) apply_chk(1'b0, 1'b0, "bnc_tail");
    check("bnc_single_fall", (n_fall - base == 1), 1'b1);

    // reset in the middle of qualification
    for (int i = 0; i < 4; i++) apply_chk(1'b0, 1'b1, "rq");
    check("rq_busy_before", busy, 1'b1);
    apply_chk(1'b1, 1'b1, "rq_rst");
    check("rq_busy_rst",  busy,         1'b0);
    check("rq_clean_rst", button_clean, 1'b0);
    edges_until(1'b1, 1'b1, "rq_rel", n);
    check("rq_rise_latency5", (n == 5), 1'b1);

    // reset while output high: drops without a fall strobe
    for (int i = 0; i < 3; i++) apply_chk(1'b0, 1'b1, "rh");
    base = n_fall;
    apply_chk(1'b1, 1'b1, "rh_rst");
    check("rh_clean_rst", button_clean, 1'b0);
    check("rh_no_fall", (n_fall == base), 1'b1);

    // pulse-stage view: each press yields exactly one rising strobe
    for (int i = 0; i < 8; i++) apply_chk(1'b0, 1'b0, "p_idle");
    base = n_rise;
    for (int i = 0; i < 20; i++) apply_chk(1'b0, 1'b1, "p_press");
    for (int i = 0; i < 20; i++) apply_chk(1'b0, 1'b0, "p_rel");
    check("p_one_pulse", (n_rise - base == 1), 1'b1);
    base = n_rise;
    apply_chk(1'b0, 1'b1, "pb");
    apply_chk(1'b0, 1'b0, "pb");
    apply_chk(1'b0, 1'b1, "pb");
    apply_chk(1'b0, 1'b0, "pb");
    apply_chk(1'b0, 1'b1, "pb");
    apply_chk(1'b0, 1'b0, "pb");
    for (int i = 0; i < 20; i++) apply_chk(1'b0, 1'b1, "pb_hold");
    for (int i = 0; i < 20; i++) apply_chk(1'b0, 1'b0, "pb_rel");
    check("pb_one_pulse", (n_rise - base == 1), 1'b1);

    // randomized runs of varying length with occasional resets
    begin
      bit lvl;
      int run;
      lvl = 1'b0;
      run = 0;
      for (int c = 0; c < 3000; c++) begin
        if (run == 0) begin
          lvl = ~lvl;
          run = $urandom_range(1, 2 * SC);
        end
        run--;
        apply_chk(($urandom_range(0, 199) == 0), lvl, "rnd");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
